// File: rtl/ram_bist_checker.sv
// Self-test engine for a single-port RAM. It writes the pattern (2*addr) to
// every location, reads all locations back in LFSR order, and reports
// pass/fail, a saturating error count and the first failing address and data.
module ram_bist_checker #(
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [ADDR_W-1:0] LFSR_TAPS = 10'h240,
    parameter logic [ADDR_W-1:0] LFSR_SEED = 10'd35
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write,
    output logic              ram_select,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int unsigned       ERR_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST     = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam logic [ADDR_W-1:0] SEED     = (LFSR_SEED == '0) ? ADDR_W'(1) : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    // Expected content of a location: address shifted left by one, truncated.
    function automatic logic [DATA_W-1:0] exp_pattern(input logic [ADDR_W-1:0] a);
        return DATA_W'({a, 1'b0});
    endfunction

    // Galois right-shift LFSR step.
    function automatic logic [ADDR_W-1:0] lfsr_next(input logic [ADDR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              write_q, write_d;
    logic              select_q, select_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [ADDR_W-1:0] first_addr_q, first_addr_d;
    logic [DATA_W-1:0] first_data_q, first_data_d;

    // Sequencer, compare pipeline and result registers.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lfsr_d       = lfsr_q;
        address_d    = '0;
        data_in_d    = '0;
        write_d      = 1'b0;
        select_d     = 1'b0;
        cmp_valid_d  = select_q & ~write_q;
        cmp_addr_d   = address_q;
        cmp_exp_d    = exp_pattern(address_q);
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        first_addr_d = first_addr_q;
        first_data_d = first_data_q;

        // Read data returns one cycle after the issue captured in cmp_*.
        if (cmp_valid_q && (ram_data_out != cmp_exp_q)) begin
            if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
            if (err_count_q == '0) begin
                first_addr_d = cmp_addr_q;
                first_data_d = ram_data_out;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_FILL;
                    lfsr_d       = SEED;
                    cnt_d        = '0;
                    address_d    = '0;
                    data_in_d    = exp_pattern('0);
                    write_d      = 1'b1;
                    select_d     = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_count_d  = '0;
                    first_addr_d = '0;
                    first_data_d = '0;
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    cmp_valid_d = 1'b0;
                end else if (address_q == LAST) begin
                    state_d   = S_READ;
                    cnt_d     = '0;
                    address_d = '0;
                    select_d  = 1'b1;
                end else begin
                    address_d = address_q + ADDR_W'(1);
                    data_in_d = exp_pattern(address_q + ADDR_W'(1));
                    write_d   = 1'b1;
                    select_d  = 1'b1;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    cmp_valid_d = 1'b0;
                end else if (cnt_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d     = cnt_q + ADDR_W'(1);
                    address_d = lfsr_q;
                    lfsr_d    = lfsr_next(lfsr_q);
                    select_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            lfsr_q       <= SEED;
            address_q    <= '0;
            data_in_q    <= '0;
            write_q      <= 1'b0;
            select_q     <= 1'b0;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= '0;
            cmp_exp_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            first_addr_q <= '0;
            first_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            address_q    <= address_d;
            data_in_q    <= data_in_d;
            write_q      <= write_d;
            select_q     <= select_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_addr_q   <= cmp_addr_d;
            cmp_exp_q    <= cmp_exp_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            first_addr_q <= first_addr_d;
            first_data_q <= first_data_d;
        end
    end

    assign ram_address    = address_q;
    assign ram_data_in    = data_in_q;
    assign ram_write      = write_q;
    assign ram_select     = select_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_addr_q;
    assign first_err_data = first_data_q;

endmodule

// File: tb/tb_ram_bist_checker.sv
// Bench for ram_bist_checker: behavioural 1024x8 RAM with injectable faults,
// scoreboard queues of expected write and read transactions.
module tb_ram_bist_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [9:0]  ram_address;
    logic [7:0]  ram_data_in;
    logic        ram_write;
    logic        ram_select;
    logic [7:0]  ram_data_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr;
    logic [7:0]  first_err_data;

    int checks   = 0;
    int failures = 0;
    int fault_mode = 0;

    logic [7:0] mem [1024];

    logic [9:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [9:0] ra_q[$];

    ram_bist_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .ram_address    (ram_address),
        .ram_data_in    (ram_data_in),
        .ram_write      (ram_write),
        .ram_select     (ram_select),
        .ram_data_out   (ram_data_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read, optional faults on reads.
    always @(posedge clk) begin
        if (ram_select) begin
            if (ram_write) begin
                mem[ram_address] <= ram_data_in;
            end else begin
                logic [7:0] rd;
                rd = mem[ram_address];
                if (fault_mode == 1 && ram_address == 10'd300) rd = 8'hFF;
                if (fault_mode == 2) rd[0] = 1'b1;
                ram_data_out <= rd;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_select, ram_write, busy, done, pass} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: sel/wr/busy/done/pass=%b required 00000",
                     {ram_select, ram_write, busy, done, pass});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({err_count, first_err_addr, first_err_data, ram_address, ram_data_in} !== 47'b0) begin
            failures++;
            $display("FAIL reset_data: err=%0d faddr=%0d fdata=%0d addr=%0d din=%0d required all 0",
                     err_count, first_err_addr, first_err_data, ram_address, ram_data_in);
        end
    endtask

    // One full run with scoreboarded transactions and final result checks.
    task automatic run_test(input string name, input int fault, input logic exp_pass,
                            input int exp_err, input int exp_faddr, input int exp_fdata,
                            input bit hold_start, input int pulse_at);
        logic [9:0] s;
        logic [9:0] ea;
        logic [7:0] ed;
        bit         seen [1024];
        int         n;
        bit         finished;
        fault_mode = fault;
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        for (int k = 0; k < 1024; k++) begin
            seen[k] = 1'b0;
            wa_q.push_back(10'(k));
            wd_q.push_back(8'(k * 2));
        end
        ra_q.push_back(10'd0);
        s = 10'd35;
        for (int k = 1; k < 1024; k++) begin
            ra_q.push_back(s);
            s = (s >> 1) ^ (s[0] ? 10'h240 : 10'h000);
        end
        start = 1'b1;
        n = 0;
        finished = 1'b0;
        while (!finished && n < 2200) begin
            @(negedge clk);
            n++;
            if (n == 1 && !hold_start) start = 1'b0;
            if (pulse_at != 0 && n == pulse_at) start = 1'b1;
            if (pulse_at != 0 && n == pulse_at + 1) start = 1'b0;
            if (ram_select && ram_write) begin
                checks++;
                if (wa_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_write: extra write addr=%0d required none", name, ram_address);
                end else begin
                    ea = wa_q.pop_front();
                    ed = wd_q.pop_front();
                    if (ram_address !== ea || ram_data_in !== ed) begin
                        failures++;
                        $display("FAIL %s_write: addr=%0d data=%0d required addr=%0d data=%0d",
                                 name, ram_address, ram_data_in, ea, ed);
                    end
                end
            end else if (ram_select) begin
                checks++;
                if (ra_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_read: extra read addr=%0d required none", name, ram_address);
                end else begin
                    ea = ra_q.pop_front();
                    if (ram_address !== ea || ram_data_in !== 8'd0) begin
                        failures++;
                        $display("FAIL %s_read: addr=%0d din=%0d required addr=%0d din=0",
                                 name, ram_address, ram_data_in, ea);
                    end
                end
                checks++;
                if (seen[ram_address]) begin
                    failures++;
                    $display("FAIL %s_unique: addr=%0d read twice required once", name, ram_address);
                end
                seen[ram_address] = 1'b1;
            end
            if (done) finished = 1'b1;
        end
        checks++;
        if (!finished || n != 2050) begin
            failures++;
            $display("FAIL %s_latency: done after %0d cycles (finished=%0d) required 2050",
                     name, n, finished);
        end
        checks++;
        if (wa_q.size() != 0 || ra_q.size() != 0) begin
            failures++;
            $display("FAIL %s_coverage: pending writes=%0d reads=%0d required 0 and 0",
                     name, wa_q.size(), ra_q.size());
        end
        checks++;
        if (pass !== exp_pass || err_count !== 11'(exp_err)) begin
            failures++;
            $display("FAIL %s_result: pass=%0d err=%0d required pass=%0d err=%0d",
                     name, pass, err_count, exp_pass, exp_err);
        end
        checks++;
        if (first_err_addr !== 10'(exp_faddr) || first_err_data !== 8'(exp_fdata)) begin
            failures++;
            $display("FAIL %s_first: addr=%0d data=%0h required addr=%0d data=%0h",
                     name, first_err_addr, first_err_data, exp_faddr, exp_fdata);
        end
        checks++;
        if (busy !== 1'b0 || ram_select !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: busy=%0d sel=%0d required 0 and 0", name, busy, ram_select);
        end
        fault_mode = 0;
    endtask

    task automatic test_good();
        run_test("good", 0, 1'b1, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_stuck_addr();
        run_test("stuck300", 1, 1'b0, 1, 300, 8'hFF, 1'b0, 0);
    endtask

    task automatic test_stuck_bit();
        run_test("bit0", 2, 1'b0, 1024, 0, 8'h01, 1'b0, 0);
    endtask

    task automatic test_abort();
        start = 1'b1;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        checks++;
        if (!(ram_select && ram_write && ram_address == 10'd499)) begin
            failures++;
            $display("FAIL abort_pre: sel=%0d wr=%0d addr=%0d required 1 1 499",
                     ram_select, ram_write, ram_address);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({ram_select, busy, done, pass} !== 4'b0) begin
            failures++;
            $display("FAIL abort_stop: sel/busy/done/pass=%b required 0000",
                     {ram_select, busy, done, pass});
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ram_select !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: sel=%0d done=%0d required 0 0", ram_select, done);
        end
        run_test("abort_rerun", 0, 1'b1, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_read();
        start = 1'b1;
        for (int n = 1; n <= 1500; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        checks++;
        if (!(ram_select && !ram_write && busy)) begin
            failures++;
            $display("FAIL rst_pre: sel=%0d wr=%0d busy=%0d required 1 0 1", ram_select, ram_write, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_select, ram_write, busy} !== 3'b0) begin
            failures++;
            $display("FAIL rst_async: sel/wr/busy=%b required 000", {ram_select, ram_write, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_select, ram_write, busy, done, pass, err_count, first_err_addr,
             first_err_data, ram_address, ram_data_in} !== 52'b0) begin
            failures++;
            $display("FAIL rst_after: sel=%0d wr=%0d busy=%0d done=%0d pass=%0d err=%0d addr=%0d required all 0",
                     ram_select, ram_write, busy, done, pass, err_count, ram_address);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (ram_select !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle: sel=%0d busy=%0d required 0 0", ram_select, busy);
        end
    endtask

    task automatic test_back_to_back();
        run_test("hold", 0, 1'b1, 0, 0, 0, 1'b1, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || ram_select !== 1'b1 || ram_write !== 1'b1
            || ram_address !== 10'd0) begin
            failures++;
            $display("FAIL restart: done=%0d busy=%0d sel=%0d wr=%0d addr=%0d required 0 1 1 1 0",
                     done, busy, ram_select, ram_write, ram_address);
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (ram_select !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL restart_abort: sel=%0d busy=%0d required 0 0", ram_select, busy);
        end
        run_test("pulse_busy", 0, 1'b1, 0, 0, 0, 1'b0, 700);
    endtask

    initial begin
        test_reset();
        test_good();
        test_stuck_addr();
        test_stuck_bit();
        test_abort();
        test_reset_mid_read();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a run wedges the bench.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
